// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller with sub-word read-modify-write
module mem_access_ctrl #(
    parameter int unsigned MEM_WORDS = 8192,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    // request side (pipeline MEM stage)
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    // response side
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respError,
    // data memory side
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One extra bit so a depth of 2^30 words still compares correctly.
    localparam logic [30:0] MEM_WORDS_W = 31'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] word_q;

    // Latched request fields; only the low halfword of store data is needed
    // after acceptance because word stores are issued straight from reqWData.
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_error_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    // Extract the addressed lane (little-endian) and sign/zero extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = word;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the captured word with right-justified store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic [15:0] data
    );
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else begin
            if (lane[1]) begin
                r[31:16] = data;
            end else begin
                r[15:0] = data;
            end
        end
        return r;
    endfunction

    assign accept = reqValid && req_ready_q;

    // Classify the incoming request: illegal size, misalignment or out-of-range index.
    always_comb begin
        req_error_d = 1'b0;
        case (reqSize)
            SZ_BYTE: req_error_d = 1'b0;
            SZ_HALF: req_error_d = reqAddr[0];
            SZ_WORD: req_error_d = (reqAddr[1:0] != 2'b00);
            default: req_error_d = 1'b1;
        endcase
        if ({1'b0, reqAddr[31:2]} >= MEM_WORDS_W) begin
            req_error_d = 1'b1;
        end
    end

    // Load result formed from the live read data so it is ready at the READ edge.
    always_comb begin
        load_data_d  = load_extract(memReadData, addr_q[1:0], size_q, unsigned_q);
        merge_data_d = store_merge(word_q, addr_q[1:0], size_q, wdata_q);
    end

    // Main FSM; every output is a register so strobes and address are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_error_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= PARK_ADDR;
            mem_wdata_q   <= 32'h0;
            word_q        <= 32'h0;
            write_q       <= 1'b0;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 16'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= reqWrite;
                        size_q      <= reqSize;
                        unsigned_q  <= reqUnsigned;
                        addr_q      <= reqAddr;
                        wdata_q     <= reqWData[15:0];
                        if (req_error_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_error_q <= 1'b1;
                        end else if (reqWrite && (reqSize == SZ_WORD)) begin
                            state_q       <= S_WRITE;
                            mem_write_q   <= 1'b1;
                            mem_address_q <= {reqAddr[31:2], 2'b00};
                            mem_wdata_q   <= reqWData;
                        end else begin
                            state_q       <= S_READ;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {reqAddr[31:2], 2'b00};
                        end
                    end
                end
                S_READ: begin
                    mem_read_q    <= 1'b0;
                    mem_address_q <= PARK_ADDR;
                    word_q        <= memReadData;
                    if (write_q) begin
                        state_q <= S_GAP;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data_d;
                        resp_error_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    // Parked address during GAP forces an address change before the write.
                    state_q       <= S_WRITE;
                    mem_write_q   <= 1'b1;
                    mem_address_q <= {addr_q[31:2], 2'b00};
                    mem_wdata_q   <= merge_data_d;
                end
                S_WRITE: begin
                    state_q       <= S_RESP;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= PARK_ADDR;
                    resp_valid_q  <= 1'b1;
                    resp_rdata_q  <= 32'h0;
                    resp_error_q  <= 1'b0;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q       <= S_IDLE;
                    req_ready_q   <= 1'b1;
                    mem_read_q    <= 1'b0;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= PARK_ADDR;
                end
            endcase
        end
    end

    assign reqReady     = req_ready_q;
    assign respValid    = resp_valid_q;
    assign respRData    = resp_rdata_q;
    assign respError    = resp_error_q;
    assign memAddress   = mem_address_q;
    assign memWriteData = mem_wdata_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;

endmodule
